toeplitz_gencol: RTL and testbench

// - Generates, one per clock, successive columns of an L x N binary Toeplitz matrix
//   (used in the privacy-amplification / hashing datapath).
// - Matrix defined by its first column col0 and first row row0; rrow0 = bit-reversed row0.
// - Constant matrix seeds come from the seed-loader block (readrc), which packs them in BS-bit words.
// - Several instances with equal STRIDE and INDEX = 0..STRIDE-1 interleave to cover all columns in parallel.

---
 rtl/toeplitz_gencol.sv | 81 ++++++++
 tb/tb_toeplitz_gencol.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/toeplitz_gencol.sv
// toeplitz_gencol: emits one column of an L x N binary Toeplitz matrix per clock.
// The column index advances by STRIDE each edge, so STRIDE instances with
// INDEX = 0..STRIDE-1 cover every column between them.
// Optional macro GENCOL_SEED_CHECK_EN adds simulation checks on seed consistency.
`timescale 1ns/1ps

module toeplitz_gencol #(
    parameter int BS     = 64,
    parameter int N      = 256,
    parameter int L      = 128,
    parameter int STRIDE = 1,
    parameter int INDEX  = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] row0,
    input  logic [N-1:0] rrow0,
    input  logic [L-1:0] col0,
    output logic [L-1:0] col
);

    localparam int unsigned CW = $clog2(N);
    localparam int unsigned VW = N - 1 + L;
    localparam int unsigned IW = $clog2(VW);

    // Reject parameter sets the column indexing cannot represent.
    generate
        if (BS < 1 || N < 2 || (N & (N - 1)) != 0 || L < 1 || L > N ||
            STRIDE < 1 || STRIDE >= N || INDEX < 0 || INDEX >= STRIDE) begin : g_bad_params
            $error("toeplitz_gencol: illegal parameter combination");
        end
    endgenerate

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt_c;
    logic [VW-1:0] vec_c;
    logic [IW-1:0] sel_c;

    // Every column is an L-bit window of col0 extended upward by row0 entries 1..N-1.
    assign vec_c     = {rrow0[N-1:1], col0};
    assign cnt_nxt_c = cnt + CW'(STRIDE);
    assign sel_c     = IW'(cnt_nxt_c);

    // Counter and column register move together so col always matches cnt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= CW'(INDEX);
            col <= vec_c[INDEX +: L];
        end else begin
            cnt <= cnt_nxt_c;
            col <= vec_c[sel_c +: L];
        end
    end

    // rrow0[0] duplicates the corner taken from col0; row0 only feeds the optional checks.
    logic unused_bits;
    assign unused_bits = ^{rrow0[0], row0};

`ifdef GENCOL_SEED_CHECK_EN
    logic [N-1:0] row0_rev_c;

    // Reference bit-reversal of row0 for the consistency check.
    always_comb begin
        row0_rev_c = '0;
        for (int k = 0; k < N; k++) begin
            row0_rev_c[k] = row0[N-1-k];
        end
    end

    // Flag inconsistent seeds while out of reset.
    always @(posedge clk) begin
        if (!reset) begin
            assert (rrow0 == row0_rev_c)
                else $error("toeplitz_gencol: rrow0 is not the bit-reverse of row0");
            assert (row0[N-1] == col0[L-1])
                else $error("toeplitz_gencol: corner mismatch between row0 and col0");
        end
    end
`endif

endmodule

// File: tb/tb_toeplitz_gencol.sv
// Bench for toeplitz_gencol: seven interleaved instances checked every cycle
// against a direct Toeplitz-rule model through an expectation queue.
`timescale 1ns/1ps

module tb_toeplitz_gencol;

    localparam int BS = 64;
    localparam int N  = 256;
    localparam int L  = 128;
    localparam int NI = 7;
    localparam int STR [NI]     = '{1, 2, 4, 2, 4, 4, 4};
    localparam int IDX [NI]     = '{0, 0, 0, 1, 1, 2, 3};
    localparam int CNT_299 [NI] = '{43, 86, 172, 87, 173, 174, 175};

    typedef struct {
        int           inst;
        int           k;
        logic [7:0]   cnt;
        logic [L-1:0] col;
    } exp_t;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] row0;
    logic [N-1:0] rrow0;
    logic [L-1:0] col0;
    logic [L-1:0] col_s [NI];

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #0.5 clk = ~clk;

    toeplitz_gencol #(.BS(BS), .N(N), .L(L), .STRIDE(1), .INDEX(0)) u_s1i0 (
        .clk(clk), .reset(reset), .row0(row0), .rrow0(rrow0), .col0(col0), .col(col_s[0]));
    toeplitz_gencol #(.BS(BS), .N(N), .L(L), .STRIDE(2), .INDEX(0)) u_s2i0 (
        .clk(clk), .reset(reset), .row0(row0), .rrow0(rrow0), .col0(col0), .col(col_s[1]));
    toeplitz_gencol #(.BS(BS), .N(N), .L(L), .STRIDE(4), .INDEX(0)) u_s4i0 (
        .clk(clk), .reset(reset), .row0(row0), .rrow0(rrow0), .col0(col0), .col(col_s[2]));
    toeplitz_gencol #(.BS(BS), .N(N), .L(L), .STRIDE(2), .INDEX(1)) u_s2i1 (
        .clk(clk), .reset(reset), .row0(row0), .rrow0(rrow0), .col0(col0), .col(col_s[3]));
    toeplitz_gencol #(.BS(BS), .N(N), .L(L), .STRIDE(4), .INDEX(1)) u_s4i1 (
        .clk(clk), .reset(reset), .row0(row0), .rrow0(rrow0), .col0(col0), .col(col_s[4]));
    toeplitz_gencol #(.BS(BS), .N(N), .L(L), .STRIDE(4), .INDEX(2)) u_s4i2 (
        .clk(clk), .reset(reset), .row0(row0), .rrow0(rrow0), .col0(col0), .col(col_s[5]));
    toeplitz_gencol #(.BS(BS), .N(N), .L(L), .STRIDE(4), .INDEX(3)) u_s4i3 (
        .clk(clk), .reset(reset), .row0(row0), .rrow0(rrow0), .col0(col0), .col(col_s[6]));

    // Count one comparison and report it if it does not match.
    task automatic chk(input string tag, input logic [L-1:0] got, input logic [L-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] get_cnt(input int s);
        case (s)
            0:       return u_s1i0.cnt;
            1:       return u_s2i0.cnt;
            2:       return u_s4i0.cnt;
            3:       return u_s2i1.cnt;
            4:       return u_s4i1.cnt;
            5:       return u_s4i2.cnt;
            default: return u_s4i3.cnt;
        endcase
    endfunction

    // T[i][j] straight from the matrix definition.
    function automatic logic tbit(input int i, input int j);
        if (i >= j) return col0[L-1-(i-j)];
        else        return row0[N-1-(j-i)];
    endfunction

    function automatic logic [L-1:0] model_col(input int j);
        logic [L-1:0] c;
        for (int i = 0; i < L; i++) c[L-1-i] = tbit(i, j);
        return c;
    endfunction

    // Fresh random seeds with a consistent corner and a true bit-reversed row.
    task automatic set_seed();
        for (int w = 0; w < N / 32; w++) row0[w*32 +: 32] = $urandom();
        for (int w = 0; w < L / 32; w++) col0[w*32 +: 32] = $urandom();
        row0[N-1] = col0[L-1];
        for (int b = 0; b < N; b++) rrow0[b] = row0[N-1-b];
    endtask

    // Queue the expected state of every instance after k edges since reset.
    task automatic push_exp(input int k);
        exp_t e;
        int   c;
        for (int s = 0; s < NI; s++) begin
            c     = (IDX[s] + k * STR[s]) % N;
            e.inst = s;
            e.k    = k;
            e.cnt  = 8'(c);
            e.col  = model_col(c);
            sb.push_back(e);
        end
    endtask

    // Drain the queue against the instances' current outputs.
    task automatic pop_chk();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("cnt s%0d k%0d", e.inst, e.k), L'(get_cnt(e.inst)), L'(e.cnt));
            chk($sformatf("col s%0d k%0d", e.inst, e.k), col_s[e.inst], e.col);
        end
    endtask

    // Advance one edge with scoreboard checks; sample a quarter period later.
    task automatic step(input int k);
        push_exp(k);
        @(posedge clk);
        #0.25;
        pop_chk();
    endtask

    initial begin
        #5000;
        $display("FAIL watchdog time limit reached checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [L-1:0] shifted;
        set_seed();
        reset = 1'b1;
        #1.0;
        reset = 1'b0;
        #0.25;
        push_exp(0);
        pop_chk();
        chk("reset col==col0 s1i0", col_s[0], col0);

        for (int k = 1; k <= 299; k++) begin
            step(k);
            if (k == 43) begin
                shifted = model_col(172) >> 1;
                shifted[L-1] = tbit(0, 173);
                chk("shift s4i1 cnt173", col_s[4], shifted);
            end
            if (k == 256) begin
                chk("wrap256 cnt", L'(u_s1i0.cnt), L'(8'd0));
                chk("wrap256 col", col_s[0], col0);
            end
            if (k == 257) chk("wrap257 col", col_s[0], model_col(1));
            if (k == 299) begin
                for (int s = 0; s < NI; s++)
                    chk($sformatf("cnt299 s%0d", s), L'(get_cnt(s)), L'(CNT_299[s]));
            end
        end

        // Asynchronous reset mid-run takes effect without a clock edge.
        reset = 1'b1;
        #0.1;
        push_exp(0);
        pop_chk();
        @(posedge clk);
        #0.5;
        reset = 1'b0;
        #0.25;
        push_exp(0);
        pop_chk();

        // Seed change mid-run shows up at the next column update.
        for (int k = 1; k <= 12; k++) begin
            if (k == 6) set_seed();
            step(k);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
